// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
//  - dec_state_t : scan-code prefix decoder states
//  - PS2_*       : set-2 prefix and keyboard-overrun byte values
//  - ps2_evt_t   : decoded key event {extended, release, code}, EVT_W bits
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  localparam int EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_evt_t;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through synchronous FIFO for decoded key events.
//  clk, reset : system clock, synchronous active-high reset
//  push, din  : write request and data (dropped when full with no pop)
//  pop        : read request, ignored when empty
//  dout       : head entry, forced to 0 while empty
//  empty/full : occupancy flags
//  level      : entries held
//  drop       : 1-cycle pulse when a push was discarded
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int EVT_W = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [EVT_W-1:0]               din,
  input  logic                           pop,
  output logic [EVT_W-1:0]               dout,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [EVT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             pop_ok, push_ok;

  assign empty   = (level == LW'(0));
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin synchroniser, 11-bit deframer with timeout,
// set-2 E0/F0 prefix decoder and event FIFO with valid/ready delivery.
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN (suppresses auto-repeat makes).
//  clk, reset                : system clock, synchronous active-high reset
//  ps2_clk, ps2_data         : raw PS/2 pins
//  evt_valid/evt_ready       : event handshake (FIFO head)
//  evt_code/release/extended : event fields
//  fifo_level                : entries held
//  overflow, clr_overflow    : sticky drop flag and its clear (set wins)
//  frame_err, err_count      : error pulse and saturating error count
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int ERRCNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [7:0]                 evt_code,
  output logic                       evt_release,
  output logic                       evt_extended,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow,
  input  logic                       clr_overflow,
  output logic                       frame_err,
  output logic [ERRCNT_W-1:0]        err_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------- synchroniser ----------------
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   fall, bit_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Idle-high preset so leaving reset never fakes a falling edge.
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign fall   = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  assign bit_in = dat_sync[SYNC_STAGES-1];

  // ---------------- deframer + timeout ----------------
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;      // [0]=start, [8:1]=data LSB first, [9]=parity
  logic [TW-1:0] idle_cnt;
  logic          byte_vld;
  logic [7:0]    byte_q;
  logic          frame_done, frame_ok, dfr_err, timeout;

  assign frame_done = fall & (bit_cnt == 4'd10);
  assign frame_ok   = ~shreg[0] & bit_in & odd_parity_ok(shreg[9:1]);
  assign dfr_err    = frame_done & ~frame_ok;
  assign timeout    = ~fall & (bit_cnt != 4'd0) &
                      (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      idle_cnt <= '0;
      byte_vld <= 1'b0;
      byte_q   <= '0;
    end else begin
      byte_vld <= frame_done & frame_ok;
      if (frame_done & frame_ok) byte_q <= shreg[8:1];
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
        end else begin
          shreg[bit_cnt] <= bit_in;
          bit_cnt        <= bit_cnt + 4'd1;
        end
      end else if (timeout) begin
        bit_cnt  <= '0;
        idle_cnt <= '0;
      end else if (bit_cnt != 4'd0) begin
        idle_cnt <= idle_cnt + TW'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // ---------------- prefix decoder FSM ----------------
  dec_state_t state, state_n;
  logic       is_pfx, is_ovr;
  logic       dec_push, dec_err;
  ps2_evt_t   dec_evt;

  assign is_pfx = (byte_q == PS2_EXT) | (byte_q == PS2_BRK);
  assign is_ovr = (byte_q == PS2_ERR0) | (byte_q == PS2_ERR1);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (dfr_err) begin
      state_n = ST_IDLE;
    end else if (byte_vld) begin
      if (is_ovr) begin
        state_n = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (byte_q == PS2_EXT)      state_n = ST_EXT;
            else if (byte_q == PS2_BRK) state_n = ST_BRK;
          end
          ST_EXT: begin
            if (byte_q == PS2_BRK)      state_n = ST_EXT_BRK;
            else if (byte_q != PS2_EXT) state_n = ST_IDLE;
          end
          default: state_n = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    dec_push     = 1'b0;
    dec_err      = 1'b0;
    dec_evt.ext  = (state == ST_EXT) | (state == ST_EXT_BRK);
    dec_evt.rel  = (state == ST_BRK) | (state == ST_EXT_BRK);
    dec_evt.code = byte_q;
    if (byte_vld) begin
      if (is_ovr) begin
        dec_err = 1'b1;
      end else begin
        case (state)
          ST_IDLE, ST_EXT: dec_push = ~is_pfx;
          default: begin
            // A prefix after F0 is a protocol violation.
            dec_err  = is_pfx;
            dec_push = ~is_pfx;
          end
        endcase
      end
    end
  end

  // ---------------- auto-repeat filter ----------------
  logic suppress;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       last_vld;
  logic [8:0] last_key;
  logic       key_match;

  assign key_match = last_vld & (last_key == {dec_evt.ext, dec_evt.code});
  assign suppress  = ~dec_evt.rel & key_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_vld <= 1'b0;
      last_key <= '0;
    end else if (dec_push) begin
      if (dec_evt.rel) begin
        if (key_match) last_vld <= 1'b0;
      end else if (!key_match) begin
        last_vld <= 1'b1;
        last_key <= {dec_evt.ext, dec_evt.code};
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  // ---------------- event FIFO ----------------
  ps2_evt_t head;
  logic     fifo_empty, fifo_full, fifo_drop;

  ps2_evt_fifo #(.DEPTH(DEPTH), .EVT_W(EVT_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (dec_push & ~suppress),
    .din   (dec_evt),
    .pop   (evt_ready),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level),
    .drop  (fifo_drop)
  );

  assign evt_valid    = ~fifo_empty;
  assign evt_code     = head.code;
  assign evt_release  = head.rel;
  assign evt_extended = head.ext;

  // ---------------- error / overflow status ----------------
  logic err_now;
  assign err_now = dfr_err | timeout | dec_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
      err_count <= '0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= err_now;
      if (err_now && err_count != {ERRCNT_W{1'b1}}) err_count <= err_count + ERRCNT_W'(1);
      if (fifo_drop)         overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // Full flag is only informational here; the FIFO handles full itself.
  logic unused_ok;
  assign unused_ok = fifo_full;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
module tb_ps2_kbd_rx;
  localparam int DEPTH = 8, SS = 3, TMO = 10000, EW = 8, H = 12;

  logic clk = 1'b0, reset, ps2_clk, ps2_data, evt_ready, clr_overflow;
  logic evt_valid, evt_release, evt_extended, overflow, frame_err;
  logic [7:0] evt_code;
  logic [$clog2(DEPTH+1)-1:0] fifo_level;
  logic [EW-1:0] err_count;

  always #5 clk = ~clk;

  ps2_kbd_rx #(.DEPTH(DEPTH), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO), .ERRCNT_W(EW)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_release(evt_release), .evt_extended(evt_extended), .fifo_level(fifo_level),
    .overflow(overflow), .clr_overflow(clr_overflow), .frame_err(frame_err),
    .err_count(err_count)
  );

  typedef struct packed { logic ext; logic rel; logic [7:0] code; } ev_t;

  ev_t  exp_q[$];
  int   n_vec = 0, n_bad = 0, exp_err = 0, err_cycles = 0, rdy_mode = 1;
  bit   m_ext, m_brk, mdl_drop;
  bit   lm_vld;
  logic [8:0] lm_key;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: key events from the byte stream by the prefix rules.
  function automatic void emit(input ev_t e);
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] key;
    key = {e.ext, e.code};
    if (!e.rel) begin
      if (lm_vld && lm_key == key) return;
      lm_vld = 1'b1;
      lm_key = key;
    end else if (lm_vld && lm_key == key) begin
      lm_vld = 1'b0;
    end
`endif
    if (mdl_drop) mdl_drop = 1'b0;
    else exp_q.push_back(e);
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int flt);
    if (flt != 0 || b == 8'h00 || b == 8'hFF) begin
      exp_err++; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0 || b == 8'hF0) begin
      if (m_brk) begin exp_err++; m_ext = 0; m_brk = 0; end
      else if (b == 8'hE0) m_ext = 1;
      else m_brk = 1;
    end else begin
      emit({m_ext, m_brk, b});
      m_ext = 0; m_brk = 0;
    end
  endfunction

  // Ready driver and scoreboard monitor share one process so the ready value
  // used for the compare is exactly the one the DUT samples next.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      case (rdy_mode)
        0: evt_ready = ($urandom_range(0, 3) != 0);
        2: evt_ready = 1'b1;
        default: evt_ready = 1'b0;
      endcase
      if (frame_err) err_cycles++;
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_event: got %0h, expected none", {evt_extended, evt_release, evt_code});
        end else begin
          e = exp_q.pop_front();
          check("event", 32'({evt_extended, evt_release, evt_code}), 32'(e));
        end
      end
    end
  end

  // flt: 0 good, 1 bad parity, 2 bad start. hook: 1 latency check, 2 ready pulse at write.
  task automatic send_frame(input logic [7:0] b, input int flt, input int hook);
    logic [10:0] f;
    model_byte(b, flt);
    f = {1'b1, (~^b) ^ (flt == 1), b, (flt == 2)};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); ps2_data = f[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && hook == 1) begin
        repeat (SS) @(negedge clk);
        check("latency_before", 32'(evt_valid), 32'(0));
        @(negedge clk);
        check("latency_at", 32'(evt_valid), 32'(1));
      end
      if (i == 10 && hook == 2) begin
        repeat (SS) @(posedge clk);
        rdy_mode = 2;
        @(posedge clk);
        rdy_mode = 1;
      end
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ps2_data = 1'($urandom_range(0, 1));
      repeat (H) @(negedge clk); ps2_clk = 1'b0;
      repeat (H) @(negedge clk); ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic checkpoint();
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin @(negedge clk); k++; end
    repeat (6) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    check("fifo_empty", 32'(fifo_level), 32'(0));
    check("err_pulses", 32'(err_cycles), 32'(exp_err));
    check("err_count", 32'(err_count), 32'((exp_err > 255) ? 255 : exp_err));
  endtask

  initial begin
    logic [7:0] b;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b0; clr_overflow = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_valid", 32'(evt_valid), 32'(0));
    check("rst_level", 32'(fifo_level), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    check("rst_frame_err", 32'(frame_err), 32'(0));
    check("rst_err_count", 32'(err_count), 32'(0));
    check("rst_code", 32'({evt_extended, evt_release, evt_code}), 32'(0));
    reset = 1'b0;

    // make/break of A, with latency on the first
    rdy_mode = 1;
    send_frame(8'h1C, 0, 1);
    rdy_mode = 0;
    send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0);
    checkpoint();

    // extended make/break
    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    checkpoint();

    // parity error, then E0 followed by a bad start bit resets decoder
    send_frame(8'h1C, 1, 0);
    checkpoint();
    send_frame(8'hE0, 0, 0); send_frame(8'h55, 2, 0); send_frame(8'h1C, 0, 0);
    checkpoint();

    // partial frame timeout
    send_bits(5);
    exp_err++;
    repeat (TMO + 50) @(negedge clk);
    send_frame(8'h29, 0, 0);
    checkpoint();

    // overflow: 9 makes into 8 entries
    rdy_mode = 1;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) mdl_drop = 1'b1;
      send_frame(8'h10 + 8'(i), 0, 0);
    end
    repeat (10) @(negedge clk);
    check("ovf_level", 32'(fifo_level), 32'(DEPTH));
    check("ovf_set", 32'(overflow), 32'(1));
    clr_overflow = 1'b1; @(negedge clk); clr_overflow = 1'b0; @(negedge clk);
    check("ovf_cleared", 32'(overflow), 32'(0));
    send_frame(8'h30, 0, 2);
    check("full_pushpop_level", 32'(fifo_level), 32'(DEPTH));
    check("full_pushpop_no_ovf", 32'(overflow), 32'(0));
    rdy_mode = 0;
    checkpoint();

    // auto-repeat sequence
    send_frame(8'h1C, 0, 0); send_frame(8'h1C, 0, 0); send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0);
    checkpoint();

    // randomized byte stream
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: send_frame(8'hE0, 0, 0);
        1: send_frame(8'hF0, 0, 0);
        2: send_frame(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00, 0, 0);
        3: send_frame(8'($urandom_range(1, 254)), 1, 0);
        default: begin
          b = 8'($urandom_range(1, 254));
          if (b == 8'hE0 || b == 8'hF0) b = 8'h2A;
          send_frame(b, 0, 0);
        end
      endcase
    end
    checkpoint();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
